// File: rtl/ssd_capture.sv
// Receive-side decoder for a multiplexed two-digit seven-segment bus: waits for each
// digit to settle, decodes it back to a nibble and reassembles the displayed byte.
module ssd_capture #(
  parameter int unsigned min_stable_p = 16,
  parameter bit          active_low_p = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] ssd_i,
  output logic [7:0] value_o,
  output logic       valid_o,
  output logic       change_o,
  output logic       error_o
);

  localparam int unsigned CntW = (min_stable_p < 1) ? 1 : $clog2(min_stable_p + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(min_stable_p);

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        s_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [3:0]        hi_q, hi_d, lo_q, lo_d;
  logic              hi_seen_q, hi_seen_d, lo_seen_q, lo_seen_d;
  logic              first_q, first_d;
  logic [7:0]        value_q, value_d;
  logic              valid_q, valid_d;
  logic              change_q, change_d;
  logic              error_q, error_d;

  logic              same_c;
  logic              capture_c;
  logic [6:0]        seg_c;
  logic [4:0]        dec_c;
  logic              is_lo_c;
  logic              other_seen_c;
  logic [7:0]        pair_c;

  // Returns {valid, nibble} for an active-high gfedcba pattern.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  assign same_c    = (ssd_i == s_q);
  assign seg_c     = active_low_p ? ~s_q[6:0] : s_q[6:0];
  assign dec_c     = decode(seg_c);
  assign is_lo_c   = s_q[7];
  assign capture_c = (state_q == SETTLE) && (count_q == CntMax) && same_c;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Any bus change restarts settling; a capture parks us until the next change.
  always_comb begin
    state_d = state_q;
    if (!same_c) begin
      state_d = SETTLE;
    end else if (capture_c) begin
      state_d = HOLD;
    end
  end

  always_comb begin
    count_d      = count_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    hi_seen_d    = hi_seen_q;
    lo_seen_d    = lo_seen_q;
    first_d      = first_q;
    value_d      = value_q;
    valid_d      = 1'b0;
    change_d     = 1'b0;
    error_d      = 1'b0;
    other_seen_c = is_lo_c ? hi_seen_q : lo_seen_q;
    pair_c       = is_lo_c ? {hi_q, dec_c[3:0]} : {dec_c[3:0], lo_q};

    if (!same_c) begin
      count_d = CntW'(1);
    end else if (count_q != CntMax) begin
      count_d = count_q + CntW'(1);
    end

    if (capture_c) begin
      if (!dec_c[4]) begin
        error_d = 1'b1;
        if (is_lo_c) lo_seen_d = 1'b0;
        else         hi_seen_d = 1'b0;
      end else begin
        if (is_lo_c) lo_d = dec_c[3:0];
        else         hi_d = dec_c[3:0];
        // Second digit of a pair publishes the byte and starts a fresh pair.
        if (other_seen_c) begin
          value_d   = pair_c;
          valid_d   = 1'b1;
          change_d  = (pair_c != value_q) | first_q;
          first_d   = 1'b0;
          hi_seen_d = 1'b0;
          lo_seen_d = 1'b0;
        end else if (is_lo_c) begin
          lo_seen_d = 1'b1;
        end else begin
          hi_seen_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s_q       <= 8'h00;
      count_q   <= '0;
      hi_q      <= 4'h0;
      lo_q      <= 4'h0;
      hi_seen_q <= 1'b0;
      lo_seen_q <= 1'b0;
      first_q   <= 1'b1;
      value_q   <= 8'h00;
      valid_q   <= 1'b0;
      change_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      s_q       <= ssd_i;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_seen_q <= hi_seen_d;
      lo_seen_q <= lo_seen_d;
      first_q   <= first_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      change_q  <= change_d;
      error_q   <= error_d;
    end
  end

  assign value_o  = value_q;
  assign valid_o  = valid_q;
  assign change_o = change_q;
  assign error_o  = error_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Scoreboard bench for ssd_capture: a dwell-level reference model predicts pulses and
// value; an active-low instance sees the same logical stimulus with inverted segments.
module tb_ssd_capture;

  localparam int MS = 4;
  localparam logic [6:0] CODES [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                         7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                         7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] ssd_i;
  logic [7:0] ssd_al;
  logic [7:0] value_o, value2_o;
  logic       valid_o, change_o, error_o;
  logic       valid2_o, change2_o, error2_o;

  assign ssd_al = {ssd_i[7], ~ssd_i[6:0]};

  ssd_capture #(.min_stable_p(MS), .active_low_p(1'b0)) dut (
    .clk_i(clk), .reset_i(reset_i), .ssd_i(ssd_i), .value_o(value_o),
    .valid_o(valid_o), .change_o(change_o), .error_o(error_o));

  ssd_capture #(.min_stable_p(MS), .active_low_p(1'b1)) dut_al (
    .clk_i(clk), .reset_i(reset_i), .ssd_i(ssd_al), .value_o(value2_o),
    .valid_o(valid2_o), .change_o(change2_o), .error_o(error2_o));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0, change_cnt = 0, error_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic v;
    logic c;
    logic e;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_value;
  logic [7:0] last_in;
  int         held;
  logic [3:0] m_hi, m_lo;
  bit         m_hi_seen, m_lo_seen, m_first;

  function automatic int lookup(input logic [6:0] seg);
    for (int i = 0; i < 16; i++) if (CODES[i] == seg) return i;
    return -1;
  endfunction

  // Reference: a value held for MS+1 edges is read once; two digits make a byte.
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      exp_q.delete();
      exp_value = 8'h00;
      last_in   = 8'h00;
      held      = 0;
      m_hi      = 4'h0;
      m_lo      = 4'h0;
      m_hi_seen = 1'b0;
      m_lo_seen = 1'b0;
      m_first   = 1'b1;
    end else begin
      int   idx;
      bit   is_lo;
      exp_t e;
      logic [7:0] nv;
      if (ssd_i != last_in) held = 1;
      else if (held < 1000) held++;
      last_in = ssd_i;
      if (held == MS + 1) begin
        idx   = lookup(ssd_i[6:0]);
        is_lo = ssd_i[7];
        e     = '{1'b0, 1'b0, 1'b0};
        if (idx < 0) begin
          e.e = 1'b1;
          if (is_lo) m_lo_seen = 1'b0; else m_hi_seen = 1'b0;
        end else begin
          if (is_lo) m_lo = 4'(idx); else m_hi = 4'(idx);
          if (is_lo ? m_hi_seen : m_lo_seen) begin
            nv        = {m_hi, m_lo};
            e.v       = 1'b1;
            e.c       = (nv != exp_value) || m_first;
            exp_value = nv;
            m_first   = 1'b0;
            m_hi_seen = 1'b0;
            m_lo_seen = 1'b0;
          end else if (is_lo) begin
            m_lo_seen = 1'b1;
          end else begin
            m_hi_seen = 1'b1;
          end
        end
        if (e.v || e.e) exp_q.push_back(e);
      end
    end
  end

  // Monitor: pulses must match the entry pushed on the preceding edge, or be idle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{1'b0, 1'b0, 1'b0};
    check("valid",     32'(valid_o),   32'(e.v));
    check("change",    32'(change_o),  32'(e.c));
    check("error",     32'(error_o),   32'(e.e));
    check("valid_al",  32'(valid2_o),  32'(e.v));
    check("change_al", 32'(change2_o), 32'(e.c));
    check("error_al",  32'(error2_o),  32'(e.e));
    check("value",     32'(value_o),   32'(exp_value));
    check("value_al",  32'(value2_o),  32'(exp_value));
    valid_cnt  += int'(valid_o);
    change_cnt += int'(change_o);
    error_cnt  += int'(error_o);
  end

  task automatic drive(input logic [7:0] v, input int n);
    ssd_i = v;
    repeat (n) @(negedge clk);
  endtask

  localparam logic [7:0] LO3 = 8'hCF;
  localparam logic [7:0] HI2 = 8'h5B;

  initial begin
    int v0, c0, e0;
    reset_i = 1'b1;
    ssd_i   = LO3;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value_o), 32'h00);
    check("rst_pulses", 32'({valid_o, change_o, error_o}), 32'h0);
    reset_i = 1'b0;

    // First pair with explicit latency check on the high digit.
    drive(LO3, 20);
    ssd_i = HI2;
    repeat (MS) @(posedge clk);
    #1 check("latency_early", 32'(valid_o), 32'h0);
    @(posedge clk);
    #1 check("latency_valid", 32'(valid_o), 32'h1);
    check("latency_change", 32'(change_o), 32'h1);
    check("latency_value", 32'(value_o), 32'h23);
    repeat (15) @(negedge clk);
    check("p1_valid_cnt", 32'(valid_cnt), 32'd1);
    check("p1_change_cnt", 32'(change_cnt), 32'd1);

    v0 = valid_cnt; c0 = change_cnt; e0 = error_cnt;
    for (int k = 0; k < 10; k++) drive((k % 2 == 0) ? LO3 : HI2, 20);
    check("alt_valid", 32'(valid_cnt - v0), 32'd5);
    check("alt_change", 32'(change_cnt - c0), 32'd0);
    check("alt_value", 32'(value_o), 32'h23);

    v0 = valid_cnt; e0 = error_cnt;
    drive(LO3, 10);
    drive(8'h86, 3);
    drive(LO3, 10);
    check("glitch_value", 32'(value_o), 32'h23);
    check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_error", 32'(error_cnt - e0), 32'd0);
    drive(HI2, 20);

    v0 = valid_cnt; c0 = change_cnt; e0 = error_cnt;
    drive(8'h00, 20);
    drive(8'hBF, 20);
    check("bad_error", 32'(error_cnt - e0), 32'd1);
    check("bad_valid", 32'(valid_cnt - v0), 32'd0);
    drive(8'h7C, 20);
    check("b0_value", 32'(value_o), 32'hB0);
    check("b0_change", 32'(change_cnt - c0), 32'd1);

    // Asynchronous reset in the middle of a settling high dwell.
    ssd_i = HI2;
    @(posedge clk);
    @(posedge clk);
    #2 reset_i = 1'b1;
    #1 check("async_rst_value", 32'(value_o), 32'h00);
    check("async_rst_pulses", 32'({valid_o, change_o, error_o}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    c0 = change_cnt;
    drive(8'h87, 20);
    drive(8'h71, 20);
    check("f7_value", 32'(value_o), 32'hF7);
    check("f7_change", 32'(change_cnt - c0), 32'd1);

    drive(8'hFF, 20);
    drive(8'h6F, 20);
    check("al_value", 32'(value2_o), 32'h98);
    check("ah_value", 32'(value_o), 32'h98);

    for (int k = 0; k < 120; k++) begin
      logic [6:0] seg;
      if ($urandom_range(0, 99) < 85) seg = CODES[$urandom_range(0, 15)];
      else seg = 7'($urandom_range(0, 127));
      drive({1'($urandom_range(0, 1)), seg}, int'($urandom_range(1, 12)));
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
